mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 16, meaning the number of WAIT cycles without bus_ack before an access aborts (used only with MAU_TIMEOUT_EN).
REQ-002 SHALL have ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  MEM stage holds a memory op.
- req_we  in  1  1=store, 0=load.
- req_op  in  3  width/sign code, same as the load extender:
  - op[0]=0 means word.
  - op[1] selects 0=byte, 1=half.
  - op[2] selects 0=unsigned, 1=signed; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze the pipeline.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completion.
- bus_rdata  in  32  raw read word.
- ld_valid  out  1  load result valid.
- ld_data  out  32  captured raw word, for the extender's din.
- ld_a  out  2  req_addr[1:0], for the extender's A.
- ld_op  out  3  req_op, for the extender's op.
- misalign  out  1  address exception.
- bus_err  out  1  timeout abort.

Function
REQ-003 SHALL implement a three-state FSM (IDLE, WAIT, DONE) with registered outputs.
REQ-004 IDLE, when req_valid=1 and the address is aligned, SHALL do the following on the next edge:
- latch we, op, addr and wdata;
- drive bus_req=1 with bus_we, bus_addr, bus_be and bus_wdata;
- enter WAIT.
REQ-005 Misaligned addresses are half with addr[0]=1, or word with addr[1:0]!=0. These SHALL:
- issue no bus access;
- go IDLE->DONE with misalign=1 and ld_valid=0.
REQ-006 WAIT SHALL hold all bus_* outputs stable until bus_ack=1 is sampled.
REQ-007 On bus_ack=1 in WAIT, the unit SHALL on that edge:
- deassert bus_req;
- capture bus_rdata into ld_data (loads only);
- enter DONE.
REQ-008 DONE SHALL last exactly one cycle and then return to IDLE. In DONE:
- ld_valid=1 for successful loads;
- misalign or bus_err is pulsed if applicable;
- stall=0.
REQ-009 stall SHALL equal req_valid AND (state!=DONE), combinationally. The minimum aligned access is therefore 2 stall cycles (request N, ack at N+1, DONE at N+2).
REQ-010 Store byte lanes SHALL be:
- byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
- half: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}};
- word: be=4'b1111, wdata unchanged.
REQ-011 Loads SHALL drive be=4'b1111 and bus_we=0.
REQ-012 SHALL ignore bus_ack in IDLE and DONE.
REQ-013 A req_valid change during WAIT SHALL NOT abort the access.
REQ-014 ld_data, ld_a and ld_op SHALL hold their values until the next load completes. Stores and misaligned ops SHALL NOT alter ld_data.
REQ-015 Back-to-back requests SHALL see one IDLE cycle between DONE and the next WAIT.

Reset
REQ-016 On a clk edge with rst_n=0, the unit SHALL:
- enter IDLE;
- clear bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_valid, ld_data, ld_a, ld_op, misalign, bus_err and the timeout counter.
REQ-017 Reset during WAIT SHALL abandon the access: bus_req=0 after that edge, and a later stale bus_ack is ignored per REQ-012.

Configuration
REQ-018 With MAU_TIMEOUT_EN defined, WAIT SHALL count cycles. On reaching BUS_TIMEOUT without ack, the unit SHALL:
- drop bus_req;
- enter DONE with bus_err=1, ld_valid=0 and ld_data unchanged.
The counter SHALL clear on entry to WAIT.
REQ-019 Without MAU_TIMEOUT_EN, WAIT SHALL persist until ack, with no counter logic and bus_err tied to 0.

Verification
REQ-020 Load word at 0x100, ack at first WAIT cycle, rdata=0xDEADBEEF. Required response:
- bus_addr=0x100, be=1111;
- stall high 2 cycles;
- ld_valid pulse with ld_data=0xDEADBEEF, ld_a=0.
REQ-021 Store byte 0xA5 to 0x203. Required response: bus_addr=0x200, be=1000, wdata=0xA5A5A5A5, bus_we=1.
REQ-022 Store half 0x1234 to 0x302. Required response: be=1100, wdata=0x12341234.
REQ-023 Load half at 0x105. Required response:
- no bus_req;
- misalign pulse in cycle 2;
- stall high 1 cycle;
- ld_data unchanged.
REQ-024 Load with ack delayed 5 cycles. Required response: bus outputs stable 5 cycles, stall high 6 cycles. Then, with MAU_TIMEOUT_EN and BUS_TIMEOUT=4 and no ack, required response: bus_err pulse after 4 WAIT cycles and bus_req=0.
REQ-025 Assert rst_n=0 mid-WAIT, then apply bus_ack=1 one cycle after reset release. Required response: IDLE, all outputs 0, no ld_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit between the MEM stage and a simple req/ack bus: lane steering, misalign
// detection and load capture. Optional bus timeout abort is enabled with `define MAU_TIMEOUT_EN.
module mem_access_unit #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [1:0]  ld_a,
    output logic [2:0]  ld_op,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [1:0]  ld_a_q, ld_a_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic        misalign_q, misalign_d;
    logic [1:0]  a_q, a_d;
    logic [2:0]  op_q, op_d;

    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        timeout;

    // Lane steering for the incoming request; loads always read the full word.
    always_comb begin
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = req_wdata;
        if (!req_op[0]) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end else if (req_op[1]) begin
            misaligned = req_addr[0];
            be_c       = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c    = {2{req_wdata[15:0]}};
        end else begin
            be_c    = 4'b0001 << req_addr[1:0];
            wdata_c = {4{req_wdata[7:0]}};
        end
        if (!req_we) be_c = 4'b1111;
    end

`ifdef MAU_TIMEOUT_EN
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    assign timeout = (cnt_q == CW'(BUS_TIMEOUT - 1));
    assign bus_err = bus_err_q;

    // Counter is zero whenever WAIT is entered and counts each WAIT cycle without ack.
    always_comb begin
        cnt_d     = '0;
        bus_err_d = 1'b0;
        if (state_q == S_WAIT && !bus_ack) begin
            if (timeout) bus_err_d = 1'b1;
            else         cnt_d     = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^BUS_TIMEOUT;
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        ld_a_d      = ld_a_q;
        ld_op_d     = ld_op_q;
        misalign_d  = 1'b0;
        a_d         = a_q;
        op_d        = op_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
                        a_d         = req_addr[1:0];
                        op_d        = req_op;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!bus_we_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = bus_rdata;
                        ld_a_d     = a_q;
                        ld_op_d    = op_q;
                    end
                end else if (timeout) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_a_q      <= '0;
            ld_op_q     <= '0;
            misalign_q  <= 1'b0;
            a_q         <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            ld_a_q      <= ld_a_d;
            ld_op_q     <= ld_op_d;
            misalign_q  <= misalign_d;
            a_q         <= a_d;
            op_q        <= op_d;
        end
    end

    assign stall     = req_valid && (state_q != S_DONE);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign ld_a      = ld_a_q;
    assign ld_op     = ld_op_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, randomized accesses against a
// behavioural model, back-to-back, reset mid-access and (with MAU_TIMEOUT_EN) bus timeout.
module tb_mem_access_unit;

    localparam int TO = 4;
`ifdef MAU_TIMEOUT_EN
    localparam int LONG_ACK = 4;
`else
    localparam int LONG_ACK = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall, bus_req, bus_we, ld_valid, misalign, bus_err;
    logic [31:0] bus_addr, bus_wdata, ld_data;
    logic [3:0]  bus_be;
    logic [1:0]  ld_a;
    logic [2:0]  ld_op;

    int n_checks = 0;
    int n_fail = 0;

    // Observations of the last access, filled in by run_access.
    int          obs_stall, obs_wait, obs_req;
    logic        obs_stable, obs_done, obs_we, obs_ldv, obs_mis, obs_err;
    logic [31:0] obs_addr, obs_wdata, obs_ldd;
    logic [3:0]  obs_be;
    logic [1:0]  obs_lda;
    logic [2:0]  obs_ldop;

    // Model of the most recent completed load, plus the expected load-data queue.
    logic [31:0] m_ld_data = '0;
    logic [1:0]  m_ld_a = '0;
    logic [2:0]  m_ld_op = '0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_a(ld_a), .ld_op(ld_op), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request from an IDLE cycle and follows it to DONE. ack_delay is the WAIT
    // cycle (1-based) in which bus_ack is raised; 0 never acks. Returns just after DONE.
    task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_delay);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        bus_ack = 1'b0; bus_rdata = ~rdata;
        obs_stall = 0; obs_wait = 0; obs_req = 0; obs_stable = 1'b1; obs_done = 1'b0;
        for (int k = 0; k < 64 && !obs_done; k++) begin
            @(negedge clk);
            if (bus_req) obs_req++;
            if (!stall) begin
                obs_done = 1'b1;
                obs_ldv = ld_valid; obs_ldd = ld_data; obs_lda = ld_a; obs_ldop = ld_op;
                obs_mis = misalign; obs_err = bus_err;
            end else begin
                obs_stall++;
                if (k > 0) begin
                    obs_wait++;
                    if (obs_wait == 1) begin
                        obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;
                    end else if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !==
                                 {1'b1, obs_we, obs_addr, obs_be, obs_wdata}) begin
                        obs_stable = 1'b0;
                    end
                end
                bus_ack   = (k > 0) && (obs_wait == ack_delay);
                bus_rdata = bus_ack ? rdata : ~rdata;
                @(posedge clk);
                #1;
            end
        end
        bus_ack = 1'b0;
        if (obs_done) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_valid, ld_data, ld_a, ld_op,
             misalign, bus_err, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bus_req=%b addr=%h be=%h wdata=%h ld_data=%h stall=%b, want all 0",
                     bus_req, bus_addr, bus_be, bus_wdata, ld_data, stall);
        end
        req_valid = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_comb: got %b want 1", stall); end
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_low: got %b want 0", stall); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_directed();
        // Load word, ack in first WAIT cycle.
        run_access(1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        n_checks++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL d_ldw_addr: got %h want 00000100", obs_addr); end
        n_checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b0) begin n_fail++; $display("FAIL d_ldw_be_we: got be=%b we=%b want 1111 0", obs_be, obs_we); end
        n_checks++; if (obs_stall !== 2) begin n_fail++; $display("FAIL d_ldw_stall: got %0d want 2", obs_stall); end
        n_checks++; if (obs_ldv !== 1'b1 || obs_ldd !== 32'hDEADBEEF || obs_lda !== 2'd0) begin
            n_fail++; $display("FAIL d_ldw_result: got v=%b d=%h a=%0d want 1 deadbeef 0", obs_ldv, obs_ldd, obs_lda); end
        n_checks++; if (obs_req !== 1) begin n_fail++; $display("FAIL d_ldw_req_cycles: got %0d want 1", obs_req); end
        // Store byte to 0x203.
        run_access(1'b1, 3'b001, 32'h203, 32'h123456A5, 32'h0, 1);
        n_checks++; if (obs_addr !== 32'h200 || obs_be !== 4'b1000 || obs_we !== 1'b1) begin
            n_fail++; $display("FAIL d_stb_bus: got addr=%h be=%b we=%b want 00000200 1000 1", obs_addr, obs_be, obs_we); end
        n_checks++; if (obs_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL d_stb_wdata: got %h want a5a5a5a5", obs_wdata); end
        n_checks++; if (obs_ldv !== 1'b0 || obs_ldd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL d_stb_ld_hold: got v=%b d=%h want 0 deadbeef", obs_ldv, obs_ldd); end
        // Store half to 0x302.
        run_access(1'b1, 3'b011, 32'h302, 32'hABCD1234, 32'h0, 1);
        n_checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h12341234) begin
            n_fail++; $display("FAIL d_sth: got be=%b wdata=%h want 1100 12341234", obs_be, obs_wdata); end
        // Misaligned load half at 0x105.
        run_access(1'b0, 3'b011, 32'h105, 32'h0, 32'h55555555, 1);
        n_checks++; if (obs_req !== 0) begin n_fail++; $display("FAIL d_mis_no_req: got %0d bus_req cycles want 0", obs_req); end
        n_checks++; if (obs_mis !== 1'b1 || obs_stall !== 1) begin
            n_fail++; $display("FAIL d_mis_pulse: got mis=%b stall=%0d want 1 1", obs_mis, obs_stall); end
        n_checks++; if (obs_ldv !== 1'b0 || obs_ldd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL d_mis_ld_hold: got v=%b d=%h want 0 deadbeef", obs_ldv, obs_ldd); end
        // Delayed ack.
        run_access(1'b0, 3'b000, 32'h104, 32'h0, 32'hCAFEF00D, LONG_ACK);
        n_checks++; if (obs_wait !== LONG_ACK || obs_stable !== 1'b1) begin
            n_fail++; $display("FAIL d_delay_bus: got wait=%0d stable=%b want %0d 1", obs_wait, obs_stable, LONG_ACK); end
        n_checks++; if (obs_stall !== LONG_ACK + 1 || obs_ldd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL d_delay_result: got stall=%0d d=%h want %0d cafef00d", obs_stall, obs_ldd, LONG_ACK + 1); end
        m_ld_data = 32'hCAFEF00D; m_ld_a = 2'd0; m_ld_op = 3'b000;
        idle(1);
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 3'b000, 32'h500, 32'h0, 32'h11223344, 1);
        run_access(1'b0, 3'b101, 32'h502, 32'h0, 32'h99887766, 2);
        n_checks++; if (obs_stall !== 3 || obs_req !== 2) begin
            n_fail++; $display("FAIL b2b_gap: got stall=%0d req=%0d want 3 2", obs_stall, obs_req); end
        n_checks++; if (obs_ldd !== 32'h99887766 || obs_lda !== 2'd2 || obs_ldop !== 3'b101) begin
            n_fail++; $display("FAIL b2b_result: got d=%h a=%0d op=%b want 99887766 2 101", obs_ldd, obs_lda, obs_ldop); end
        m_ld_data = 32'h99887766; m_ld_a = 2'd2; m_ld_op = 3'b101;
        idle(1);
    endtask

    task automatic test_random(input int n);
        logic we, mis, tmo, exp_ldv;
        logic [2:0] op;
        logic [31:0] addr, wdata, rdata, ewd, popped;
        logic [3:0] ebe;
        int ack, size, est, ereq;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            ack = $urandom_range(1, 6);
            tmo = 1'b0;
`ifdef MAU_TIMEOUT_EN
            if ($urandom_range(0, 3) == 0) ack = 0;
            tmo = (ack == 0) || (ack > TO);
`endif
            size = (op[0] == 1'b0) ? 4 : (op[1] ? 2 : 1);
            mis = (addr % size) != 0;
            ebe = (!we || size == 4) ? 4'hF : (size == 2) ? 4'(4'b0011 << (addr & 2)) : 4'(1 << (addr & 3));
            ewd = (size == 4) ? wdata : (size == 2) ? wdata[15:0] * 32'h00010001 : wdata[7:0] * 32'h01010101;
            exp_ldv = !mis && !tmo && !we;
            est  = mis ? 1 : tmo ? TO + 1 : ack + 1;
            ereq = mis ? 0 : tmo ? TO : ack;
            if (exp_ldv) begin
                exp_q.push_back(rdata);
                m_ld_data = rdata; m_ld_a = addr[1:0]; m_ld_op = op;
            end
            run_access(we, op, addr, wdata, rdata, ack);
            n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL r%0d_done: no DONE within budget", i); end
            n_checks++; if (obs_stall !== est || obs_req !== ereq) begin
                n_fail++; $display("FAIL r%0d_timing: got stall=%0d req=%0d want %0d %0d", i, obs_stall, obs_req, est, ereq); end
            n_checks++; if (obs_mis !== mis || obs_err !== tmo || obs_ldv !== exp_ldv) begin
                n_fail++; $display("FAIL r%0d_flags: got mis=%b err=%b ldv=%b want %b %b %b", i, obs_mis, obs_err, obs_ldv, mis, tmo, exp_ldv); end
            if (!mis) begin
                n_checks++; if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== ebe || obs_we !== we || obs_stable !== 1'b1) begin
                    n_fail++; $display("FAIL r%0d_bus: got addr=%h be=%b we=%b stable=%b want %h %b %b 1", i, obs_addr, obs_be, obs_we, obs_stable, {addr[31:2], 2'b00}, ebe, we); end
                if (we) begin
                    n_checks++; if (obs_wdata !== ewd) begin n_fail++; $display("FAIL r%0d_wdata: got %h want %h", i, obs_wdata, ewd); end
                end
            end
            if (obs_ldv === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL r%0d_ld_unexpected: got ld_valid with data %h", i, obs_ldd);
                end else begin
                    popped = exp_q.pop_front();
                    if (obs_ldd !== popped) begin n_fail++; $display("FAIL r%0d_ld_data: got %h want %h", i, obs_ldd, popped); end
                end
            end
            n_checks++; if (obs_ldd !== m_ld_data || obs_lda !== m_ld_a || obs_ldop !== m_ld_op) begin
                n_fail++; $display("FAIL r%0d_ld_hold: got d=%h a=%0d op=%b want %h %0d %b", i, obs_ldd, obs_lda, obs_ldop, m_ld_data, m_ld_a, m_ld_op); end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL r_queue_drain: got %0d left want 0", exp_q.size()); end
    endtask

`ifdef MAU_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1'b0, 3'b000, 32'h600, 32'h0, 32'h0BADF00D, 0);
        n_checks++; if (obs_err !== 1'b1 || obs_wait !== TO || obs_req !== TO) begin
            n_fail++; $display("FAIL to_abort: got err=%b wait=%0d req=%0d want 1 %0d %0d", obs_err, obs_wait, obs_req, TO, TO); end
        n_checks++; if (obs_ldv !== 1'b0 || obs_ldd !== m_ld_data) begin
            n_fail++; $display("FAIL to_ld_hold: got v=%b d=%h want 0 %h", obs_ldv, obs_ldd, m_ld_data); end
        idle(1);
    endtask
`endif

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h400; req_wdata = 32'h77777777;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rw_in_wait: got bus_req=%b want 1", bus_req); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; req_valid = 1'b0; bus_rdata = 32'hFEEDFACE;
        m_ld_data = '0; m_ld_a = '0; m_ld_op = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_valid, ld_data, ld_a, ld_op,
                 misalign, bus_err, stall} !== '0) begin
                n_fail++;
                $display("FAIL rw_cleared_%0d: got bus_req=%b addr=%h be=%h ld_valid=%b ld_data=%h want all 0",
                         k, bus_req, bus_addr, bus_be, ld_valid, ld_data);
            end
            @(posedge clk);
            #1;
            bus_ack = (k == 0);
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(40);
`ifdef MAU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
